spi_lcd_rx: RTL and testbench

Receive-side endpoint of the 3-wire LCD serial link (CSX, SCL, SDA) used between the TinyFPGA BX and the display panel. It oversamples the asynchronous link pins with the 16 MHz board clock, deserializes 18-bit RGB pixel words, and presents them on a valid/ready output port. It serves as a loopback checker for our LCD driver and as a panel-emulator front end for on-board debug.

---
 rtl/spi_lcd_rx_if.sv | 28 ++
 rtl/spi_lcd_rx.sv | 124 ++++++++++++
 tb/tb_spi_lcd_rx.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_lcd_rx_if.sv
// Bus bundle for spi_lcd_rx: 3-wire LCD link pins on one side, pixel word
// valid/ready port and status flags on the other.
interface spi_lcd_rx_if #(
    parameter int WORD_W = 18
);
    logic              CSX_I;
    logic              SCL_I;
    logic              SDA_I;
    logic [WORD_W-1:0] DATA;
    logic              VALID;
    logic              READY;
    logic              OVERRUN;
    logic              CLR_OVR;
    logic              FRAME_ERR;
    logic              BUSY;

    // Receiver side: consumes the link pins, produces words and status.
    modport slave (
        input  CSX_I, SCL_I, SDA_I, READY, CLR_OVR,
        output DATA, VALID, OVERRUN, FRAME_ERR, BUSY
    );

    // Link driver / word consumer side.
    modport master (
        output CSX_I, SCL_I, SDA_I, READY, CLR_OVR,
        input  DATA, VALID, OVERRUN, FRAME_ERR, BUSY
    );
endinterface

// File: rtl/spi_lcd_rx.sv
// Oversampling receiver for the 3-wire LCD link: deserializes WORD_W-bit words onto a valid/ready port.
// Build option: define SPI_LCD_RX_MSB_FIRST_EN for MSB-first bit order (default is LSB first).
module spi_lcd_rx #(
    parameter int WORD_W = 18
) (
    input  logic        CLK,
    input  logic        RESX,
    spi_lcd_rx_if.slave bus
);
    localparam int               CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_t;

    state_t            r_state;
    logic              r_csx_s1, r_csx_s2;
    logic              r_scl_s1, r_scl_s2, r_scl_s3;
    logic              r_sda_s1, r_sda_s2;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic              r_frame_err;
    logic              r_busy;

    logic              w_scl_rise;
    logic              w_word_done;
    logic              w_ovr_set;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [WORD_W-1:0] w_shift_next;

    assign w_scl_rise  = r_scl_s2 & ~r_scl_s3;
    assign w_word_done = (r_state == SHIFT) & w_scl_rise & (r_bit_cnt == LAST_BIT);
    assign w_ovr_set   = w_word_done & r_valid & ~bus.READY;
    assign w_cnt_next  = (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;

`ifdef SPI_LCD_RX_MSB_FIRST_EN
    assign w_shift_next = {r_shift[WORD_W-2:0], r_sda_s2};
`else
    assign w_shift_next = {r_sda_s2, r_shift[WORD_W-1:1]};
`endif

    // NOTE: every register here uses non-blocking assignment so all of them
    // update from pre-edge values, keeping the synchronizer chains intact.
    always_ff @(posedge CLK) begin
        if (!RESX) begin
            // Synchronizers clear too, so WAIT_IDLE must see a genuine CSX high.
            r_csx_s1    <= 1'b0;
            r_csx_s2    <= 1'b0;
            r_scl_s1    <= 1'b0;
            r_scl_s2    <= 1'b0;
            r_scl_s3    <= 1'b0;
            r_sda_s1    <= 1'b0;
            r_sda_s2    <= 1'b0;
            r_state     <= WAIT_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_csx_s1    <= bus.CSX_I;
            r_csx_s2    <= r_csx_s1;
            r_scl_s1    <= bus.SCL_I;
            r_scl_s2    <= r_scl_s1;
            r_scl_s3    <= r_scl_s2;
            r_sda_s1    <= bus.SDA_I;
            r_sda_s2    <= r_sda_s1;
            r_frame_err <= 1'b0;

            case (r_state)
                WAIT_IDLE: begin
                    if (r_csx_s2) r_state <= IDLE;
                end
                IDLE: begin
                    if (!r_csx_s2) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_scl_rise) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= w_cnt_next;
                    end
                    // A same-cycle final bit completes the word before the frame check.
                    if (r_csx_s2) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if ((w_scl_rise ? w_cnt_next : r_bit_cnt) != '0) r_frame_err <= 1'b1;
                    end
                end
                default: r_state <= WAIT_IDLE;
            endcase

            if (w_word_done) begin
                if (!r_valid || bus.READY) begin
                    r_data  <= w_shift_next;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && bus.READY) begin
                r_valid <= 1'b0;
            end

            if (w_ovr_set) r_overrun <= 1'b1;
            else if (bus.CLR_OVR) r_overrun <= 1'b0;
        end
    end

    assign bus.DATA      = r_data;
    assign bus.VALID     = r_valid;
    assign bus.OVERRUN   = r_overrun;
    assign bus.FRAME_ERR = r_frame_err;
    assign bus.BUSY      = r_busy;
endmodule

// File: tb/tb_spi_lcd_rx.sv
// Bench for spi_lcd_rx: directed scenarios plus randomized frames, checked every cycle
// against a frame-level reference model that treats each pin change as visible 3 edges later.
module tb_spi_lcd_rx;
    localparam int W = 18;

    logic clk = 1'b0;
    logic resx;

    spi_lcd_rx_if #(.WORD_W(W)) bus ();

    spi_lcd_rx #(.WORD_W(W)) dut (
        .CLK  (clk),
        .RESX (resx),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         h_ok[8], h_csx[8], h_scl[8], h_sda[8];
    int         cyc = 0;
    bit         m_armed, m_in_frame, m_valid, m_ovr, m_ferr, m_busy;
    logic [W-1:0] m_data;
    bit         m_bits[$];

    function automatic logic [W-1:0] assemble();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
`ifdef SPI_LCD_RX_MSB_FIRST_EN
            w[W-1-i] = m_bits[i];
`else
            w[i] = m_bits[i];
`endif
        end
        return w;
    endfunction

    task automatic model_step();
        int           e;
        bit           ok1, ok2, ok3, csx_seen, scl_seen, scl_prev, sda_seen, done, ovr_set;
        logic [W-1:0] word;
        e = cyc;
        h_ok[e % 8]  = resx;
        h_csx[e % 8] = bus.CSX_I;
        h_scl[e % 8] = bus.SCL_I;
        h_sda[e % 8] = bus.SDA_I;
        cyc++;
        ok1      = h_ok[(e + 7) % 8];
        ok2      = h_ok[(e + 6) % 8];
        ok3      = h_ok[(e + 5) % 8];
        csx_seen = h_csx[(e + 6) % 8] & ok2 & ok1;
        scl_seen = h_scl[(e + 6) % 8] & ok2 & ok1;
        sda_seen = h_sda[(e + 6) % 8] & ok2 & ok1;
        scl_prev = h_scl[(e + 5) % 8] & ok3 & ok2 & ok1;
        if (!resx) begin
            m_armed = 0; m_in_frame = 0; m_bits.delete();
            m_data = '0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_busy = 0;
            return;
        end
        m_ferr = 0;
        done   = 0;
        word   = '0;
        if (!m_armed) begin
            m_armed = csx_seen;
        end else if (!m_in_frame) begin
            if (!csx_seen) begin
                m_in_frame = 1;
                m_bits.delete();
            end
        end else begin
            if (scl_seen && !scl_prev) begin
                m_bits.push_back(sda_seen);
                if (m_bits.size() == W) begin
                    done = 1;
                    word = assemble();
                    m_bits.delete();
                end
            end
            if (csx_seen) begin
                m_in_frame = 0;
                if (m_bits.size() != 0) m_ferr = 1;
            end
        end
        ovr_set = done && m_valid && !bus.READY;
        if (done) begin
            if (!m_valid || bus.READY) begin
                m_data  = word;
                m_valid = 1;
            end
        end else if (m_valid && bus.READY) begin
            m_valid = 0;
        end
        if (ovr_set) m_ovr = 1;
        else if (bus.CLR_OVR) m_ovr = 0;
        m_busy = m_in_frame;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    int n_vrise = 0;
    int n_ferr  = 0;
    bit prev_valid = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("valid",     bus.VALID,     m_valid);
            check("data",      bus.DATA,      m_data);
            check("overrun",   bus.OVERRUN,   m_ovr);
            check("frame_err", bus.FRAME_ERR, m_ferr);
            check("busy",      bus.BUSY,      m_busy);
            if (bus.VALID === 1'b1 && !prev_valid) n_vrise++;
            prev_valid = (bus.VALID === 1'b1);
            if (bus.FRAME_ERR === 1'b1) n_ferr++;
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_mode = 0;

    initial forever begin
        @(negedge clk);
        if (rnd_mode) begin
            bus.READY   = ($urandom % 3) != 0;
            bus.CLR_OVR = ($urandom % 20) == 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input int lo, input int hi);
        bus.SDA_I = b;
        idle(lo);
        bus.SCL_I = 1'b1;
        idle(hi);
        bus.SCL_I = 1'b0;
    endtask

    function automatic bit bit_at(input logic [W-1:0] w, input int pos);
`ifdef SPI_LCD_RX_MSB_FIRST_EN
        return w[W-1-pos];
`else
        return w[pos];
`endif
    endfunction

    task automatic send_bits(input logic [W-1:0] w, input int from, input int to,
                             input int lo, input int hi);
        for (int i = from; i < to; i++) send_bit(bit_at(w, i), lo, hi);
    endtask

    task automatic frame_begin();
        bus.CSX_I = 1'b0;
        idle(4);
    endtask

    task automatic frame_end();
        bus.CSX_I = 1'b1;
        idle(8);
    endtask

    int v0, f0;

    initial begin
        resx        = 1'b0;
        bus.CSX_I   = 1'b1;
        bus.SCL_I   = 1'b0;
        bus.SDA_I   = 1'b0;
        bus.READY   = 1'b1;
        bus.CLR_OVR = 1'b0;
        idle(4);
        check("rst_data",  bus.DATA,      0);
        check("rst_valid", bus.VALID,     0);
        check("rst_ovr",   bus.OVERRUN,   0);
        check("rst_ferr",  bus.FRAME_ERR, 0);
        check("rst_busy",  bus.BUSY,      0);
        resx = 1'b1;
        idle(6);

        // Single word, consumer always ready.
        v0 = n_vrise; f0 = n_ferr;
        frame_begin();
        send_bits(18'h20E31, 0, W, 4, 4);
        frame_end();
        check("t1_vpulses", n_vrise - v0, 1);
        check("t1_data",    bus.DATA, 18'h20E31);
        check("t1_ferr",    n_ferr - f0, 0);

        // Two words back to back with the consumer stalled.
        bus.READY = 1'b0;
        frame_begin();
        send_bits(18'h3FFFF, 0, W, 3, 3);
        send_bits(18'h00001, 0, W, 3, 3);
        frame_end();
        check("t2_data",  bus.DATA, 18'h3FFFF);
        check("t2_ovr",   bus.OVERRUN, 1);
        check("t2_valid", bus.VALID, 1);
        bus.CLR_OVR = 1'b1;
        idle(1);
        bus.CLR_OVR = 1'b0;
        idle(1);
        check("t2_ovr_clr", bus.OVERRUN, 0);
        bus.READY = 1'b1;
        idle(3);
        check("t2_drained", bus.VALID, 0);

        // Partial frame then a good one.
        v0 = n_vrise; f0 = n_ferr;
        frame_begin();
        send_bits(18'h0007F, 0, 7, 4, 3);
        frame_end();
        check("t3_ferr_cycles", n_ferr - f0, 1);
        check("t3_no_valid",    n_vrise - v0, 0);
        frame_begin();
        send_bits(18'h15555, 0, W, 3, 4);
        frame_end();
        check("t3_data", bus.DATA, 18'h15555);

        // Reset in the middle of a word.
        frame_begin();
        send_bits(18'h3C3C3, 0, 9, 4, 4);
        v0 = n_vrise;
        resx = 1'b0;
        idle(3);
        resx = 1'b1;
        send_bits(18'h3C3C3, 9, W, 4, 4);
        frame_end();
        check("t4_no_valid", n_vrise - v0, 0);
        check("t4_data_rst", bus.DATA, 0);
        frame_begin();
        send_bits(18'h2AAAA, 0, W, 4, 4);
        frame_end();
        check("t4_data", bus.DATA, 18'h2AAAA);

        // Final SCL rise coincides with CSX rise.
        v0 = n_vrise; f0 = n_ferr;
        frame_begin();
        send_bits(18'h1B2D4, 0, W - 1, 4, 4);
        bus.SDA_I = bit_at(18'h1B2D4, W - 1);
        idle(4);
        bus.SCL_I = 1'b1;
        bus.CSX_I = 1'b1;
        idle(4);
        bus.SCL_I = 1'b0;
        idle(8);
        check("t5_vpulses", n_vrise - v0, 1);
        check("t5_data",    bus.DATA, 18'h1B2D4);
        check("t5_ferr",    n_ferr - f0, 0);

        // Randomized frames, random consumer stalls and overrun clears.
        rnd_mode = 1;
        for (int f = 0; f < 25; f++) begin
            int nw;
            nw = 1 + $urandom % 3;
            frame_begin();
            for (int k = 0; k < nw; k++) begin
                logic [W-1:0] w;
                int           lo, hi;
                w  = W'($urandom);
                lo = 3 + $urandom % 4;
                hi = 3 + $urandom % 4;
                send_bits(w, 0, W, lo, hi);
            end
            if ($urandom % 4 == 0) send_bits(W'($urandom), 0, 1 + $urandom % (W - 1), 3, 3);
            bus.CSX_I = 1'b1;
            idle(4 + $urandom % 5);
        end
        rnd_mode    = 0;
        bus.READY   = 1'b1;
        bus.CLR_OVR = 1'b1;
        idle(2);
        bus.CLR_OVR = 1'b0;
        idle(4);
        check("end_valid", bus.VALID, 0);
        check("end_ovr",   bus.OVERRUN, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        repeat (80000) @(posedge clk);
        n_total++;
        n_bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
